// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order memory requests, response FIFO and
// redirect/flush handling feeding a valid/ready {pc, inst, error} stream.
module fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int unsigned QDEPTH          = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 redir_valid,
    input  logic [31:0]                          redir_pc,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic [31:0]                          mem_req_addr,
    input  logic                                 mem_resp_valid,
    input  logic [31:0]                          mem_resp_data,
    input  logic                                 mem_resp_err,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [31:0]                          out_pc,
    output logic [31:0]                          out_inst,
    output logic                                 out_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] inflight
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } entry_t;

    state_t        state, state_n;
    entry_t        fifo_mem [QDEPTH];
    entry_t        head, push_entry;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic [IW-1:0] inflight_n, drop_cnt, drop_n;
    logic [31:0]   fetch_pc, resp_pc, npc, misalign_pc;
    logic          misalign_pend;
    logic          acc, hold, misaligned, resp_drop, push_resp, push, pop;
    logic          room, req_valid_n;

    // Next-state evaluation shared by the control register block.
    always_comb begin
        acc        = mem_req_valid && mem_req_ready;
        hold       = mem_req_valid && !mem_req_ready;
        misaligned = redir_valid && (redir_pc[1:0] != 2'b00);
        resp_drop  = (drop_cnt != '0) || (state == HALT) || redir_valid;
        push_resp  = mem_resp_valid && !resp_drop;
        push       = push_resp || misalign_pend;
        pop        = out_valid && out_ready;
        push_entry = misalign_pend ? {misalign_pc, 32'h0, 1'b1}
                                   : {resp_pc, mem_resp_data, mem_resp_err};

        count_n    = redir_valid ? '0 : count + CW'(push) - CW'(pop);
        inflight_n = inflight + IW'(acc) - IW'(mem_resp_valid);

        state_n = state;
        if (redir_valid)
            state_n = misaligned ? HALT : RUN;
        else if (push_resp && mem_resp_err)
            state_n = HALT;

        // Every issued request reserves a FIFO slot, so responses never overflow.
        room = ((32'(count_n) + 32'(inflight_n)) < QDEPTH) &&
               (32'(inflight_n) < MAX_OUTSTANDING);
        req_valid_n = hold || ((state_n == RUN) && room);
        npc = redir_valid ? redir_pc : fetch_pc;

        // A request stuck on the bus during a redirect is still owed a drop.
        drop_n = drop_cnt;
        if (redir_valid)
            drop_n = inflight_n + IW'(hold);
        else if (mem_resp_valid && (drop_cnt != '0))
            drop_n = drop_cnt - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= RUN;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= RESET_PC;
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            drop_cnt      <= '0;
            inflight      <= '0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            misalign_pend <= 1'b0;
            misalign_pc   <= '0;
        end else begin
            state         <= state_n;
            mem_req_valid <= req_valid_n;
            if (!hold)
                mem_req_addr <= npc;
            fetch_pc      <= (req_valid_n && !hold) ? npc + 32'd4 : npc;
            resp_pc       <= redir_valid ? redir_pc
                                         : (push_resp ? resp_pc + 32'd4 : resp_pc);
            drop_cnt      <= drop_n;
            inflight      <= inflight_n;
            count         <= count_n;
            misalign_pend <= misaligned;
            if (misaligned)
                misalign_pc <= redir_pc;
            if (redir_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Entry storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !redir_valid)
            fifo_mem[wr_ptr] <= push_entry;
    end

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc   : 32'h0;
    assign out_inst  = out_valid ? head.inst : 32'h0;
    assign out_err   = out_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a latency-configurable memory model feeds
// responses, and expected decode entries are queued as responses are driven.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;
    logic [1:0]  inflight;

    fetch_queue #(
        .RESET_PC(RESET_PC),
        .QDEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redir_valid(redir_valid),
        .redir_pc(redir_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .mem_resp_err(mem_resp_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .out_err(out_err),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    mreq_t       pend[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    bit          rdy = 1'b0;
    bit          orq = 1'b0;
    bit          halted = 1'b0;
    bit          after_err = 1'b0;
    bit          stale_pend = 1'b0;
    bit          fp_valid = 1'b0;
    logic [31:0] stale_addr = 32'h0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] err_addr = 32'h0000_0001;
    logic [31:0] fp_pc = 32'h0;
    logic [31:0] last_acc = 32'h0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs, score pops and requests, then advance.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        mreq_t m;
        exp_t  e;
        redir_valid    = redir;
        redir_pc       = rpc;
        mem_req_ready  = rdy;
        out_ready      = orq;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        mem_resp_err   = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = inst_of(m.addr);
            mem_resp_err   = (m.addr == err_addr);
            if (m.live && !redir)
                sb.push_back({m.addr, inst_of(m.addr), (m.addr == err_addr)});
        end
        if (out_valid && out_ready) begin
            pop_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got pc=%h inst=%h err=%b, expected no entry",
                         out_pc, out_inst, out_err);
            end else begin
                e = sb.pop_front();
                if ({out_pc, out_inst, out_err} !== e) begin
                    errors++;
                    $display("FAIL out_entry: got pc=%h inst=%h err=%b, expected pc=%h inst=%h err=%b",
                             out_pc, out_inst, out_err, e.pc, e.inst, e.err);
                end
            end
            if (!fp_valid) begin
                fp_valid = 1'b1;
                fp_pc    = out_pc;
            end
            if (out_err)
                halted = 1'b1;
        end
        if (stale_pend) begin
            checks++;
            if (!(mem_req_valid === 1'b1 && mem_req_addr === stale_addr)) begin
                errors++;
                $display("FAIL req_hold: got valid=%b addr=%h, expected valid=1 addr=%h",
                         mem_req_valid, mem_req_addr, stale_addr);
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            acc_cnt++;
            last_acc = mem_req_addr;
            if (stale_pend) begin
                stale_pend = 1'b0;
                pend.push_back('{mem_req_addr, 1'b0, cyc + lat});
            end else begin
                checks++;
                if (halted) begin
                    errors++;
                    $display("FAIL req_in_halt: got request addr=%h, expected no request", mem_req_addr);
                end else if (mem_req_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL req_addr: got %h, expected %h", mem_req_addr, exp_addr);
                end
                pend.push_back('{mem_req_addr, !after_err, cyc + lat});
                if (mem_req_addr == err_addr)
                    after_err = 1'b1;
                exp_addr = exp_addr + 32'd4;
            end
        end
        if (redir) begin
            foreach (pend[i]) pend[i].live = 1'b0;
            sb.delete();
            fp_valid = 1'b0;
            if (mem_req_valid && !mem_req_ready) begin
                stale_pend = 1'b1;
                stale_addr = mem_req_addr;
            end
            exp_addr  = rpc;
            after_err = 1'b0;
            halted    = (rpc[1:0] != 2'b00);
            if (halted)
                sb.push_back({rpc, 32'h0, 1'b1});
        end
        @(posedge clk);
        #1;
        cyc++;
        redir_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redir_valid = 1'b0; redir_pc = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0; mem_resp_err = 1'b0; out_ready = 1'b0;
        pend.delete(); sb.delete();
        exp_addr = RESET_PC; halted = 1'b0; after_err = 1'b0;
        stale_pend = 1'b0; fp_valid = 1'b0; acc_cnt = 0; pop_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        rdy = 1'b0;
        orq = 1'b1;
        for (int i = 0; i < 60 && (pend.size() != 0 || sb.size() != 0); i++)
            tick(1'b0, 32'h0);
        checks++;
        if (pend.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d entries still expected, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            checks++;
            if ({mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err, inflight} !==
                {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL reset_state: got req_valid=%b addr=%h out_valid=%b pc=%h inst=%h err=%b inflight=%0d, expected 0 %h 0 0 0 0 0",
                         mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err, inflight, RESET_PC);
            end
            rdy = 1'b1; orq = 1'b1; lat = 1;
            repeat (7) tick(1'b0, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        rdy = 1'b1; orq = 1'b1; lat = 1;
        repeat (10) tick(1'b0, 32'h0);
        p0 = pop_cnt;
        repeat (16) tick(1'b0, 32'h0);
        checks++;
        if (pop_cnt - p0 != 16) begin
            errors++;
            $display("FAIL throughput: got %0d pops in 16 cycles, expected 16", pop_cnt - p0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy = 1'b1; orq = 1'b0; lat = 1;
        repeat (20) tick(1'b0, 32'h0);
        checks++;
        if (acc_cnt != 4 || mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_fill: got accepts=%0d req_valid=%b out_valid=%b, expected 4 0 1",
                     acc_cnt, mem_req_valid, out_valid);
        end
        orq = 1'b1;
        for (int i = 0; i < 30 && acc_cnt < 5; i++)
            tick(1'b0, 32'h0);
        checks++;
        if (acc_cnt < 5 || last_acc !== 32'h8000_0010) begin
            errors++;
            $display("FAIL backpressure_resume: got accepts=%0d last addr=%h, expected 5 80000010",
                     acc_cnt, last_acc);
        end
        drain();
    endtask

    task automatic test_redirect();
        do_reset();
        rdy = 1'b1; orq = 1'b0; lat = 3;
        for (int i = 0; i < 30 && !(inflight == 2'd2 && out_valid); i++)
            tick(1'b0, 32'h0);
        checks++;
        if (!(inflight == 2'd2 && out_valid)) begin
            errors++;
            $display("FAIL redirect_setup: got inflight=%0d out_valid=%b, expected 2 1", inflight, out_valid);
        end
        tick(1'b1, 32'h8000_0100);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got out_valid=%b, expected 0", out_valid);
        end
        orq = 1'b1;
        for (int i = 0; i < 30 && !fp_valid; i++)
            tick(1'b0, 32'h0);
        checks++;
        if (!fp_valid || fp_pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redirect_first: got pc=%h (seen=%b), expected 80000100", fp_pc, fp_valid);
        end
        drain();
        lat = 1;
    endtask

    task automatic test_redirect_held();
        do_reset();
        rdy = 1'b1; orq = 1'b1; lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid && mem_req_addr == 32'h8000_0008) begin
                rdy = 1'b0;
                break;
            end
            tick(1'b0, 32'h0);
        end
        checks++;
        if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h8000_0008)) begin
            errors++;
            $display("FAIL held_setup: got valid=%b addr=%h, expected 1 80000008", mem_req_valid, mem_req_addr);
        end
        repeat (2) tick(1'b0, 32'h0);
        tick(1'b1, 32'h8000_0300);
        repeat (3) tick(1'b0, 32'h0);
        rdy = 1'b1;
        for (int i = 0; i < 30 && !fp_valid; i++)
            tick(1'b0, 32'h0);
        checks++;
        if (!fp_valid || fp_pc !== 32'h8000_0300) begin
            errors++;
            $display("FAIL held_first: got pc=%h (seen=%b), expected 80000300", fp_pc, fp_valid);
        end
        drain();
    endtask

    task automatic test_error_halt();
        do_reset();
        err_addr = 32'h8000_000C;
        rdy = 1'b1; orq = 1'b1; lat = 1;
        repeat (30) tick(1'b0, 32'h0);
        checks++;
        if (!halted || sb.size() != 0 || out_valid !== 1'b0 || mem_req_valid !== 1'b0 || inflight !== 2'd0) begin
            errors++;
            $display("FAIL error_halt: got err_seen=%b pending=%0d out_valid=%b req_valid=%b inflight=%0d, expected 1 0 0 0 0",
                     halted, sb.size(), out_valid, mem_req_valid, inflight);
        end
        tick(1'b1, 32'h8000_0200);
        for (int i = 0; i < 30 && !fp_valid; i++)
            tick(1'b0, 32'h0);
        checks++;
        if (!fp_valid || fp_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL error_restart: got pc=%h (seen=%b), expected 80000200", fp_pc, fp_valid);
        end
        drain();
        err_addr = 32'h0000_0001;
    endtask

    task automatic test_misaligned();
        do_reset();
        rdy = 1'b1; orq = 1'b1; lat = 1;
        repeat (5) tick(1'b0, 32'h0);
        tick(1'b1, 32'h8000_0102);
        repeat (20) tick(1'b0, 32'h0);
        checks++;
        if (!fp_valid || fp_pc !== 32'h8000_0102 || sb.size() != 0 ||
            mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: got first pc=%h seen=%b pending=%0d req_valid=%b out_valid=%b, expected 80000102 1 0 0 0",
                     fp_pc, fp_valid, sb.size(), mem_req_valid, out_valid);
        end
        tick(1'b1, 32'h8000_0400);
        for (int i = 0; i < 30 && !fp_valid; i++)
            tick(1'b0, 32'h0);
        checks++;
        if (!fp_valid || fp_pc !== 32'h8000_0400) begin
            errors++;
            $display("FAIL misaligned_restart: got pc=%h (seen=%b), expected 80000400", fp_pc, fp_valid);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect();
        test_redirect_held();
        test_error_halt();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
